// File: rtl/strong_more_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : strong_more_pkg                                           |
// | Brief    : Shared width constants and compare-result type.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package strong_more_pkg;

  localparam int CMP_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_t;

endpackage : strong_more_pkg
`default_nettype wire

// File: rtl/strong_more_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : strong_more_if                                            |
// | Brief    : Operand bits and compare/status outputs of strong_more.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface strong_more_if;
  import strong_more_pkg::*;

  logic             a0, a1, a2, a3;
  logic             b0, b1, b2, b3;
  logic             y;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic [CNT_W-1:0] gt_cnt;

  modport master (
    output a0, a1, a2, a3, b0, b1, b2, b3,
    input  y, gt_q, eq_q, lt_q, gt_cnt
  );

  modport slave (
    input  a0, a1, a2, a3, b0, b1, b2, b3,
    output y, gt_q, eq_q, lt_q, gt_cnt
  );

endinterface : strong_more_if
`default_nettype wire

// File: rtl/strong_more_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : strong_more_cell                                          |
// | Brief    : One bit stage of the MSB-first magnitude compare cascade. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module strong_more_cell
  import strong_more_pkg::*;
(
  input  wire logic a_bit,
  input  wire logic b_bit,
  input  wire cmp_t cmp_in,
  output cmp_t      cmp_out
);

  // A more significant stage that already decided wins outright.
  always_comb begin
    cmp_out = cmp_in;
    if (cmp_in == CMP_EQ) begin
      if (a_bit && !b_bit) begin
        cmp_out = CMP_GT;
      end else if (!a_bit && b_bit) begin
        cmp_out = CMP_LT;
      end
    end
  end

endmodule : strong_more_cell
`default_nettype wire

// File: rtl/strong_more.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : strong_more                                               |
// | Brief    : 4-bit A > B comparator with registered GT/EQ/LT flags and |
// |            a saturating "greater" cycle counter.                     |
// |            Define STRONG_MORE_SIGNED_EN for two's complement operands.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module strong_more
  import strong_more_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    reset,
  strong_more_if.slave bus
);

  logic [CMP_W-1:0] a_vec;
  logic [CMP_W-1:0] b_vec;
  cmp_t             chain [0:CMP_W];
  cmp_t             result;

  assign a_vec = {bus.a3, bus.a2, bus.a1, bus.a0};
  assign b_vec = {bus.b3, bus.b2, bus.b1, bus.b0};

  assign chain[CMP_W] = CMP_EQ;

  for (genvar i = 0; i < CMP_W; i++) begin : g_cell
    strong_more_cell u_cell (
      .a_bit   (a_vec[i]),
      .b_bit   (b_vec[i]),
      .cmp_in  (chain[i+1]),
      .cmp_out (chain[i])
    );
  end

`ifdef STRONG_MORE_SIGNED_EN
  // Differing sign bits: the operand with the clear sign bit is larger.
  always_comb begin
    result = chain[0];
    if (a_vec[CMP_W-1] != b_vec[CMP_W-1]) begin
      result = b_vec[CMP_W-1] ? CMP_GT : CMP_LT;
    end
  end
`else
  always_comb begin
    result = chain[0];
  end
`endif

  assign bus.y = (result == CMP_GT);

  logic             gt_d, eq_d, lt_d;
  logic             gt_q, eq_q, lt_q;
  logic [CNT_W-1:0] gt_cnt_d, gt_cnt_q;

  always_comb begin
    gt_d     = (result == CMP_GT);
    eq_d     = (result == CMP_EQ);
    lt_d     = (result == CMP_LT);
    gt_cnt_d = gt_cnt_q;
    if (gt_d && (gt_cnt_q != {CNT_W{1'b1}})) begin
      gt_cnt_d = gt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_cnt_q <= '0;
    end else begin
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_cnt_q <= gt_cnt_d;
    end
  end

  assign bus.gt_q   = gt_q;
  assign bus.eq_q   = eq_q;
  assign bus.lt_q   = lt_q;
  assign bus.gt_cnt = gt_cnt_q;

endmodule : strong_more
`default_nettype wire

// File: tb/tb_strong_more.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_strong_more                                            |
// | Brief    : Directed and exhaustive self-checking bench for           |
// |            strong_more (honours STRONG_MORE_SIGNED_EN).              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_strong_more;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  strong_more_if bus ();

  strong_more dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ab(input logic [3:0] a, input logic [3:0] b);
    {bus.a3, bus.a2, bus.a1, bus.a0} = a;
    {bus.b3, bus.b2, bus.b1, bus.b0} = b;
  endtask

  function automatic logic ref_gt(input logic [3:0] a, input logic [3:0] b);
`ifdef STRONG_MORE_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    set_ab(4'h3, 4'h1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.gt_q, bus.eq_q, bus.lt_q} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {bus.gt_q, bus.eq_q, bus.lt_q});
    end
    total++;
    if (bus.gt_cnt !== 8'h00) begin
      bad++; $display("FAIL reset_cnt: got %h want 00", bus.gt_cnt);
    end
    total++;
    if (bus.y !== 1'b1) begin
      bad++; $display("FAIL reset_y: got %b want 1", bus.y);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic       vy [4];
    logic [7:0] cnt;
    va[0] = 4'b0000; vb[0] = 4'b0111; vy[0] = 1'b0;
    va[1] = 4'b0111; vb[1] = 4'b0000; vy[1] = 1'b1;
`ifdef STRONG_MORE_SIGNED_EN
    va[2] = 4'b0111; vb[2] = 4'b1010; vy[2] = 1'b1;
    va[3] = 4'b1001; vb[3] = 4'b0110; vy[3] = 1'b0;
`else
    va[2] = 4'b0111; vb[2] = 4'b1010; vy[2] = 1'b0;
    va[3] = 4'b1001; vb[3] = 4'b0110; vy[3] = 1'b1;
`endif
    cnt = bus.gt_cnt;
    for (int i = 0; i < 4; i++) begin
      set_ab(va[i], vb[i]);
      #1;
      total++;
      if (bus.y !== vy[i]) begin
        bad++; $display("FAIL dir_y[%0d]: got %b want %b", i, bus.y, vy[i]);
      end
      @(posedge clk); #1;
      if (vy[i]) cnt++;
      total++;
      if ({bus.gt_q, bus.eq_q, bus.lt_q} !== {vy[i], 1'b0, ~vy[i]}) begin
        bad++; $display("FAIL dir_flags[%0d]: got %b want %b", i,
                        {bus.gt_q, bus.eq_q, bus.lt_q}, {vy[i], 1'b0, ~vy[i]});
      end
      total++;
      if (bus.gt_cnt !== cnt) begin
        bad++; $display("FAIL dir_cnt[%0d]: got %h want %h", i, bus.gt_cnt, cnt);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] cnt;
    logic       g;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 8'h00;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        set_ab(4'(a), 4'(b));
        g = ref_gt(4'(a), 4'(b));
        #1;
        total++;
        if (bus.y !== g) begin
          bad++; $display("FAIL exh_y a=%h b=%h: got %b want %b", a, b, bus.y, g);
        end
        @(posedge clk); #1;
        if (g) cnt++;
        total++;
        if ({bus.gt_q, bus.eq_q, bus.lt_q} !== {g, a == b, !g && a != b}) begin
          bad++; $display("FAIL exh_flags a=%h b=%h: got %b want %b", a, b,
                          {bus.gt_q, bus.eq_q, bus.lt_q}, {g, a == b, !g && a != b});
        end
      end
    end
    total++;
    if (bus.gt_cnt !== cnt) begin
      bad++; $display("FAIL exh_cnt: got %h want %h", bus.gt_cnt, cnt);
    end
  endtask

  task automatic test_saturate_and_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef STRONG_MORE_SIGNED_EN
    set_ab(4'h7, 4'h8);
`else
    set_ab(4'hF, 4'h0);
`endif
    repeat (254) @(posedge clk);
    #1;
    total++;
    if (bus.gt_cnt !== 8'hFE) begin
      bad++; $display("FAIL sat_254: got %h want fe", bus.gt_cnt);
    end
    repeat (46) @(posedge clk);
    #1;
    total++;
    if (bus.gt_cnt !== 8'hFF) begin
      bad++; $display("FAIL sat_300: got %h want ff", bus.gt_cnt);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.gt_cnt !== 8'h00) begin
      bad++; $display("FAIL sat_rst_cnt: got %h want 00", bus.gt_cnt);
    end
    total++;
    if ({bus.gt_q, bus.eq_q, bus.lt_q} !== 3'b000) begin
      bad++; $display("FAIL sat_rst_flags: got %b want 000", {bus.gt_q, bus.eq_q, bus.lt_q});
    end
    total++;
    if (bus.y !== 1'b1) begin
      bad++; $display("FAIL sat_rst_y: got %b want 1", bus.y);
    end
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_ab(4'h0, 4'h0);
    test_reset();
    test_directed();
    test_exhaustive();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_strong_more
`default_nettype wire
